pwm_duty_ramp: RTL and testbench

- Upstream duty-cycle sequencer for the 4-channel PWM array; drives each PWM channel's 8-bit duty_cycle input.
- Accepts target-duty commands over a valid/ready interface.
- Ramps each channel's live duty toward its target in bounded steps, changing values only at PWM period boundaries so no PWM period ever sees a mid-period duty change.

---
 rtl/pwm_duty_ramp.sv | 134 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer for a PWM array: latches target-duty commands and ramps each
// channel's live duty toward its target only at PWM period boundaries.
// Optional feature macro: DUTY_RAMP_BYPASS_EN adds cmd_bypass (jump straight to target).
module pwm_duty_ramp #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned STEP = 1,
  parameter int unsigned DIV  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_ch,
  input  logic [7:0]       cmd_duty,
`ifdef DUTY_RAMP_BYPASS_EN
  input  logic             cmd_bypass,
`endif
  output logic [8*NCH-1:0] duty_out,
  output logic [NCH-1:0]   ramp_busy,
  output logic             period_end
);

  localparam int unsigned DW       = 8;
  localparam int unsigned CHW      = 3;
  localparam int unsigned DIVW     = 16;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DW-1:0]   STEP_B   = DW'(STEP);

  typedef struct packed {
`ifdef DUTY_RAMP_BYPASS_EN
    logic           bypass;
`endif
    logic [CHW-1:0] ch;
    logic [DW-1:0]  duty;
  } hold_t;

  logic [DW-1:0]   r_phase;
  logic [DIVW-1:0] r_div_cnt;
  logic [DW-1:0]   r_target [NCH];
  logic [DW-1:0]   r_live   [NCH];
  logic            r_hold_vld;
  hold_t           r_hold;

  logic            w_ramp_tick;
  logic            w_apply;
  logic            w_accept;
  hold_t           w_cmd;
  logic [DW-1:0]   w_target_nxt [NCH];
  logic [DW-1:0]   w_live_nxt   [NCH];

  // One bounded ramp step; 9-bit compares keep it from overshooting or wrapping.
  function automatic logic [DW-1:0] f_ramp(input logic [DW-1:0] live,
                                           input logic [DW-1:0] target);
    logic [DW:0] w_up;
    f_ramp = live;
    w_up   = {1'b0, live} + {1'b0, STEP_B};
    if (live < target) begin
      if (w_up >= {1'b0, target}) f_ramp = target;
      else                        f_ramp = w_up[DW-1:0];
    end else if (live > target) begin
      if ({1'b0, live} <= ({1'b0, target} + {1'b0, STEP_B})) f_ramp = target;
      else                                                   f_ramp = live - STEP_B;
    end
  endfunction

  // Handshake, period boundary and ramp-tick decode
  always_comb begin
    period_end  = (r_phase == 8'hFF);
    w_ramp_tick = period_end && (r_div_cnt == DIV_LAST);
    w_apply     = period_end && r_hold_vld;
    cmd_ready   = !r_hold_vld;
    w_accept    = cmd_valid && !r_hold_vld;
    w_cmd       = '0;
    w_cmd.ch    = cmd_ch;
    w_cmd.duty  = cmd_duty;
`ifdef DUTY_RAMP_BYPASS_EN
    w_cmd.bypass = cmd_bypass;
`endif
  end

  // Next target/live per channel; the ramp uses the pre-update target
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_target_nxt[i] = r_target[i];
      w_live_nxt[i]   = r_live[i];
      if (w_ramp_tick) w_live_nxt[i] = f_ramp(r_live[i], r_target[i]);
      if (w_apply && (r_hold.ch == CHW'(i))) begin
        w_target_nxt[i] = r_hold.duty;
`ifdef DUTY_RAMP_BYPASS_EN
        if (r_hold.bypass) w_live_nxt[i] = r_hold.duty;
`endif
      end
    end
  end

  always_comb begin
    duty_out  = '0;
    ramp_busy = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_out[DW*i +: DW] = r_live[i];
      ramp_busy[i]         = (r_live[i] != r_target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_div_cnt  <= '0;
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_target[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      r_phase <= r_phase + 8'd1;
      if (period_end) begin
        if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
        else                       r_div_cnt <= r_div_cnt + DIVW'(1);
      end
      if (w_apply) begin
        r_hold_vld <= 1'b0;
      end else if (w_accept) begin
        r_hold_vld <= 1'b1;
        r_hold     <= w_cmd;
      end
      for (int i = 0; i < NCH; i++) begin
        r_target[i] <= w_target_nxt[i];
        r_live[i]   <= w_live_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: three instances (STEP/DIV variants) share clock
// and reset; expected duty vectors are queued per period boundary and popped there.
module tb_pwm_duty_ramp;

  logic        clk;
  logic        rst_n;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [2:0]  cmd_ch;
  logic [7:0]  cmd_duty;
`ifdef DUTY_RAMP_BYPASS_EN
  logic        cmd_bypass;
`endif
  logic [31:0] dout0, dout1, dout2;
  logic [3:0]  busy0, busy1, busy2;
  logic        pe0, pe1, pe2;

  int          n_vec;
  int          n_err;
  int          tcyc;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] exp_v;

  pwm_duty_ramp #(.NCH(4), .STEP(1), .DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty),
`ifdef DUTY_RAMP_BYPASS_EN
    .cmd_bypass(cmd_bypass),
`endif
    .duty_out(dout0), .ramp_busy(busy0), .period_end(pe0));

  pwm_duty_ramp #(.NCH(4), .STEP(4), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty),
`ifdef DUTY_RAMP_BYPASS_EN
    .cmd_bypass(cmd_bypass),
`endif
    .duty_out(dout1), .ramp_busy(busy1), .period_end(pe1));

  pwm_duty_ramp #(.NCH(4), .STEP(255), .DIV(3)) u2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld[2]), .cmd_ready(rdy[2]),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty),
`ifdef DUTY_RAMP_BYPASS_EN
    .cmd_bypass(cmd_bypass),
`endif
    .duty_out(dout2), .ramp_busy(busy2), .period_end(pe2));

  always #5 clk = ~clk;

  // Cycle index since reset release; phase = tcyc % 256
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcyc <= 0;
    else        tcyc <= tcyc + 1;
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the edge that ends a period_end cycle; returns 1 ns after it
  task automatic next_boundary(output bit ok);
    bit p;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      p = pe0;
      @(posedge clk);
      if (p) begin
        #1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_cmd(input int idx, input logic [2:0] ch, input logic [7:0] duty,
                          input logic byp, output bit ok);
    bit r;
    r        = 1'b0;
    cmd_ch   = ch;
    cmd_duty = duty;
`ifdef DUTY_RAMP_BYPASS_EN
    cmd_bypass = byp;
`else
    if (byp) $display("note: bypass requested in a build without it");
`endif
    vld[idx] = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      r = rdy[idx];
      @(posedge clk);
      if (r) break;
    end
    #1;
    vld[idx] = 1'b0;
    ok = r;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL rst_duty0: got %h want 0", dout0); end
    n_vec++; if (dout2 !== 32'h0) begin n_err++; $display("FAIL rst_duty2: got %h want 0", dout2); end
    n_vec++; if (rdy !== 3'b111) begin n_err++; $display("FAIL rst_ready: got %b want 111", rdy); end
    n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy0); end
    n_vec++; if (pe0 !== 1'b0) begin n_err++; $display("FAIL rst_pe: got %b want 0", pe0); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (pe0 !== 1'b0) begin n_err++; $display("FAIL pe_c0: got %b want 0", pe0); end
    adv(254);
    n_vec++; if (pe0 !== 1'b0) begin n_err++; $display("FAIL pe_c254: got %b want 0", pe0); end
    adv(1);
    n_vec++; if (pe0 !== 1'b1) begin n_err++; $display("FAIL pe_c255: got %b want 1", pe0); end
    adv(1);
    n_vec++; if (pe0 !== 1'b0) begin n_err++; $display("FAIL pe_c256: got %b want 0", pe0); end
    adv(255);
    n_vec++; if (pe0 !== 1'b1) begin n_err++; $display("FAIL pe_c511: got %b want 1", pe0); end
    adv(256);
    n_vec++; if (pe0 !== 1'b1) begin n_err++; $display("FAIL pe_c767: got %b want 1", pe0); end
    n_vec++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL idle_duty: got %h want 0", dout0); end
  endtask

  task automatic test_ramp();
    bit ok;
    int idx;
    do_reset();
    adv(5);
    send_cmd(0, 3'd0, 8'd10, 1'b0, ok);
    n_vec++; if (!ok || rdy[0] !== 1'b0) begin n_err++; $display("FAIL ramp_ready_c6: got %b want 0", rdy[0]); end
    for (int k = 0; k <= 10; k++) q0.push_back(32'(k));
    adv(249);
    n_vec++; if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL ramp_ready_c255: got %b want 0", rdy[0]); end
    n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL ramp_busy_c255: got %b want 0", busy0); end
    idx = 0;
    while (q0.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL ramp_timeout: got 0 want 1"); break; end
      exp_v = q0.pop_front();
      n_vec++; if (dout0 !== exp_v) begin n_err++; $display("FAIL ramp_duty[%0d]: got %h want %h", idx, dout0, exp_v); end
      if (idx == 0) begin
        n_vec++; if (busy0 !== 4'b0001) begin n_err++; $display("FAIL ramp_busy_c256: got %b want 0001", busy0); end
        adv(1);
        n_vec++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL ramp_ready_c257: got %b want 1", rdy[0]); end
      end
      if (idx == 9) begin
        n_vec++; if (busy0 !== 4'b0001) begin n_err++; $display("FAIL ramp_busy_mid: got %b want 0001", busy0); end
      end
      idx++;
    end
    n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL ramp_busy_done: got %b want 0", busy0); end
  endtask

  task automatic test_step_clamp();
    bit ok;
    int idx;
    send_cmd(1, 3'd0, 8'd10, 1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL step_hs: got 0 want 1"); end
    q1.push_back(32'd0); q1.push_back(32'd4); q1.push_back(32'd8); q1.push_back(32'd10);
    idx = 0;
    while (q1.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL step_timeout: got 0 want 1"); break; end
      exp_v = q1.pop_front();
      n_vec++; if (dout1 !== exp_v) begin n_err++; $display("FAIL step_up[%0d]: got %h want %h", idx, dout1, exp_v); end
      idx++;
    end
    send_cmd(1, 3'd0, 8'd0, 1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL step_hs2: got 0 want 1"); end
    q1.push_back(32'd10); q1.push_back(32'd6); q1.push_back(32'd2);
    q1.push_back(32'd0);  q1.push_back(32'd0);
    idx = 0;
    while (q1.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL step_timeout2: got 0 want 1"); break; end
      exp_v = q1.pop_front();
      n_vec++; if (dout1 !== exp_v) begin n_err++; $display("FAIL step_down[%0d]: got %h want %h", idx, dout1, exp_v); end
      idx++;
    end
    n_vec++; if (busy1 !== 4'h0) begin n_err++; $display("FAIL step_busy: got %b want 0", busy1); end
  endtask

  task automatic test_div();
    bit ok;
    bit synced;
    int idx;
    synced = 1'b0;
    for (int n = 0; n < 4; n++) begin
      next_boundary(ok);
      if (ok && ((tcyc / 256) % 3 == 2)) begin
        synced = 1'b1;
        break;
      end
    end
    n_vec++; if (!synced) begin n_err++; $display("FAIL div_sync: got 0 want 1"); end
    // Next period_end is a ramp tick; target lands on that same edge
    send_cmd(2, 3'd0, 8'd200, 1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL div_hs: got 0 want 1"); end
    q2.push_back(32'd0); q2.push_back(32'd0); q2.push_back(32'd0);
    q2.push_back(32'd200); q2.push_back(32'd200);
    idx = 0;
    while (q2.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL div_timeout: got 0 want 1"); break; end
      exp_v = q2.pop_front();
      n_vec++; if (dout2 !== exp_v) begin n_err++; $display("FAIL div_duty[%0d]: got %h want %h", idx, dout2, exp_v); end
      if (idx == 0) begin
        n_vec++; if (busy2 !== 4'b0001) begin n_err++; $display("FAIL div_busy: got %b want 0001", busy2); end
      end
      idx++;
    end
    n_vec++; if (busy2 !== 4'h0) begin n_err++; $display("FAIL div_busy_done: got %b want 0", busy2); end
  endtask

  task automatic test_discard();
    bit ok;
    int idx;
    send_cmd(0, 3'd5, 8'd77, 1'b0, ok);
    n_vec++; if (!ok || rdy[0] !== 1'b0) begin n_err++; $display("FAIL disc_hs: got %b want 0", rdy[0]); end
    q0.push_back(32'h0000_000A); q0.push_back(32'h0000_000A);
    idx = 0;
    while (q0.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL disc_timeout: got 0 want 1"); break; end
      exp_v = q0.pop_front();
      n_vec++; if (dout0 !== exp_v) begin n_err++; $display("FAIL disc_duty[%0d]: got %h want %h", idx, dout0, exp_v); end
      n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL disc_busy[%0d]: got %b want 0", idx, busy0); end
      idx++;
    end
    n_vec++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL disc_ready: got %b want 1", rdy[0]); end
    send_cmd(0, 3'd3, 8'd2, 1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ch3_hs: got 0 want 1"); end
    q0.push_back(32'h0000_000A); q0.push_back(32'h0100_000A); q0.push_back(32'h0200_000A);
    idx = 0;
    while (q0.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL ch3_timeout: got 0 want 1"); break; end
      exp_v = q0.pop_front();
      n_vec++; if (dout0 !== exp_v) begin n_err++; $display("FAIL ch3_duty[%0d]: got %h want %h", idx, dout0, exp_v); end
      idx++;
    end
    n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL ch3_busy: got %b want 0", busy0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int idx;
    send_cmd(1, 3'd1, 8'd100, 1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_hs: got 0 want 1"); end
    q1.push_back(32'h0000); q1.push_back(32'h0400); q1.push_back(32'h0800);
    q1.push_back(32'h0C00); q1.push_back(32'h1000);
    idx = 0;
    while (q1.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL mid_timeout: got 0 want 1"); break; end
      exp_v = q1.pop_front();
      n_vec++; if (dout1 !== exp_v) begin n_err++; $display("FAIL mid_duty[%0d]: got %h want %h", idx, dout1, exp_v); end
      idx++;
    end
    send_cmd(0, 3'd0, 8'd99, 1'b0, ok);
    n_vec++; if (!ok || rdy[0] !== 1'b0) begin n_err++; $display("FAIL mid_pending: got %b want 0", rdy[0]); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL mid_rst_d0: got %h want 0", dout0); end
    n_vec++; if (dout1 !== 32'h0) begin n_err++; $display("FAIL mid_rst_d1: got %h want 0", dout1); end
    n_vec++; if (dout2 !== 32'h0) begin n_err++; $display("FAIL mid_rst_d2: got %h want 0", dout2); end
    n_vec++; if (rdy !== 3'b111) begin n_err++; $display("FAIL mid_rst_rdy: got %b want 111", rdy); end
    n_vec++; if (busy1 !== 4'h0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy1); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    adv(254);
    n_vec++; if (pe0 !== 1'b0) begin n_err++; $display("FAIL mid_pe254: got %b want 0", pe0); end
    adv(1);
    n_vec++; if (pe0 !== 1'b1) begin n_err++; $display("FAIL mid_pe255: got %b want 1", pe0); end
    next_boundary(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_timeout2: got 0 want 1"); end
    n_vec++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL mid_after_d0: got %h want 0", dout0); end
    n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL mid_after_busy: got %b want 0", busy0); end
  endtask

`ifdef DUTY_RAMP_BYPASS_EN
  task automatic test_bypass();
    bit ok;
    int idx;
    send_cmd(0, 3'd2, 8'd128, 1'b1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL byp_hs: got 0 want 1"); end
    q0.push_back(32'h0080_0000); q0.push_back(32'h0080_0000);
    idx = 0;
    while (q0.size() > 0) begin
      next_boundary(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL byp_timeout: got 0 want 1"); break; end
      exp_v = q0.pop_front();
      n_vec++; if (dout0 !== exp_v) begin n_err++; $display("FAIL byp_duty[%0d]: got %h want %h", idx, dout0, exp_v); end
      n_vec++; if (busy0 !== 4'h0) begin n_err++; $display("FAIL byp_busy[%0d]: got %b want 0", idx, busy0); end
      idx++;
    end
    cmd_bypass = 1'b0;
  endtask
`endif

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    vld      = 3'b000;
    cmd_ch   = 3'd0;
    cmd_duty = 8'd0;
`ifdef DUTY_RAMP_BYPASS_EN
    cmd_bypass = 1'b0;
`endif
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_ramp();
    test_step_clamp();
    test_div();
    test_discard();
    test_reset_mid();
`ifdef DUTY_RAMP_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
